mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_if.sv | 37 +++
 rtl/mux_scan_ctrl_dwell_timer.sv | 32 +++
 rtl/mux_scan_ctrl.sv | 109 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Imported by the interface, the dwell timer and the top level.
package mux_scan_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int SEL_W       = 2;
  localparam int NUM_CH      = 4;
  localparam int FRAME_CNT_W = 8;

  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Control/status bundle between the scan sequencer and its user.
// The slave side is the sequencer, the master side drives it.
interface mux_scan_if;
  import mux_scan_pkg::*;

  logic                   start;
  logic                   continuous;
  logic                   y_in;
  logic [SEL_W-1:0]       sel;
  logic                   busy;
  logic [NUM_CH-1:0]      sample;
  logic                   valid;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport slave (
    input  start,
    input  continuous,
    input  y_in,
    output sel,
    output busy,
    output sample,
    output valid,
    output frame_cnt
  );

  modport master (
    output start,
    output continuous,
    output y_in,
    input  sel,
    input  busy,
    input  sample,
    input  valid,
    input  frame_cnt
  );

endinterface

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and wraps.
// tc flags the last cycle of a dwell period.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through all channels, samples each
// at the end of its dwell and emits a 4-bit frame with a valid pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_if.slave   bus
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  state_t                 state, state_n;
  logic [SEL_W-1:0]       sel, sel_n;
  logic [NUM_CH-2:0]      shadow, shadow_n;
  logic [NUM_CH-1:0]      sample, sample_n;
  logic                   valid, valid_n;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic                   tc;
  logic                   tmr_clr;
  logic                   tmr_en;

  assign tmr_clr = (state == IDLE) && bus.start;
  assign tmr_en  = (state == SCAN);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      shadow    <= '0;
      sample    <= '0;
      valid     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      shadow    <= shadow_n;
      sample    <= sample_n;
      valid     <= valid_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    shadow_n    = shadow;
    sample_n    = sample;
    valid_n     = 1'b0;
    frame_cnt_n = frame_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SCAN;
          sel_n   = '0;
        end
      end
      SCAN: begin
        unique case (1'b1)
          !tc: begin
            sel_n = sel;
          end
          tc && (sel != SEL_LAST): begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
              if (sel == SEL_W'(i)) shadow_n[i] = bus.y_in;
            end
            sel_n = sel + 1'b1;
          end
          tc && (sel == SEL_LAST): begin
            sample_n    = {bus.y_in, shadow};
            valid_n     = 1'b1;
            frame_cnt_n = frame_cnt + 1'b1;
            // continuous is only looked at here, at frame end
            if (bus.continuous) begin
              sel_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
          default: begin
            sel_n = sel;
          end
        endcase
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.sel       = sel;
  assign bus.busy      = (state == SCAN);
  assign bus.sample    = sample;
  assign bus.valid     = valid;
  assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: three sequencers (DWELL 4, 2, 1) each driving
// a 4:1 mux over constant channel inputs.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] c4 = 4'b0;
  logic [3:0] c2 = 4'b0;
  logic [3:0] c1 = 4'b0;

  int tests = 0;
  int fails = 0;

  mux_scan_if b4 ();
  mux_scan_if b2 ();
  mux_scan_if b1 ();

  assign b4.y_in = c4[b4.sel];
  assign b2.y_in = c2[b2.sel];
  assign b1.y_in = c1[b1.sel];

  mux_scan_ctrl #(.DWELL(4)) u_d4 (.clk(clk), .rst(rst), .bus(b4));
  mux_scan_ctrl #(.DWELL(2)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
  mux_scan_ctrl #(.DWELL(1)) u_d1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    b4.start = 0; b4.continuous = 0;
    b2.start = 0; b2.continuous = 0;
    b1.start = 0; b1.continuous = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({b4.sel, b4.busy, b4.sample, b4.valid, b4.frame_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL reset_d4 got sel=%0d busy=%b sample=%b valid=%b fc=%0d want all 0",
               b4.sel, b4.busy, b4.sample, b4.valid, b4.frame_cnt);
    end
    tests++;
    if ({b2.sel, b2.busy, b2.valid, b1.sel, b1.busy, b1.valid} !== 8'h0) begin
      fails++;
      $display("FAIL reset_d2_d1 got %b want 0",
               {b2.sel, b2.busy, b2.valid, b1.sel, b1.busy, b1.valid});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_shot();
    logic [1:0] es;
    c4 = 4'b1101;
    b4.continuous = 0;
    b4.start = 1;
    @(negedge clk);
    b4.start = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      es = (k < 16) ? 2'(k / 4) : 2'd3;
      tests++;
      if (b4.sel !== es) begin
        fails++;
        $display("FAIL one_shot_sel k=%0d got %0d want %0d", k, b4.sel, es);
      end
      tests++;
      if (b4.valid !== (k == 16)) begin
        fails++;
        $display("FAIL one_shot_valid k=%0d got %b want %b", k, b4.valid, k == 16);
      end
      tests++;
      if (b4.busy !== (k < 16)) begin
        fails++;
        $display("FAIL one_shot_busy k=%0d got %b want %b", k, b4.busy, k < 16);
      end
    end
    tests++;
    if (b4.sample !== 4'b1101) begin
      fails++;
      $display("FAIL one_shot_sample got %b want 1101", b4.sample);
    end
    tests++;
    if (b4.frame_cnt !== 8'd1) begin
      fails++;
      $display("FAIL one_shot_fc got %0d want 1", b4.frame_cnt);
    end
  endtask

  task automatic test_continuous();
    logic [1:0] es;
    logic [3:0] exp_s;
    c2 = 4'b0000;
    b2.continuous = 1;
    b2.start = 1;
    @(negedge clk);
    b2.start = 0;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) @(negedge clk);
      es = (k < 24) ? 2'((k % 8) / 2) : 2'd3;
      tests++;
      if (b2.sel !== es) begin
        fails++;
        $display("FAIL cont_sel k=%0d got %0d want %0d", k, b2.sel, es);
      end
      tests++;
      if (b2.valid !== (k == 8 || k == 16 || k == 24)) begin
        fails++;
        $display("FAIL cont_valid k=%0d got %b", k, b2.valid);
      end
      tests++;
      if (b2.busy !== (k < 24)) begin
        fails++;
        $display("FAIL cont_busy k=%0d got %b want %b", k, b2.busy, k < 24);
      end
      if (k == 8 || k == 16 || k == 24) begin
        exp_s = (k == 8) ? 4'b0000 : 4'b1111;
        tests++;
        if (b2.sample !== exp_s) begin
          fails++;
          $display("FAIL cont_sample k=%0d got %b want %b", k, b2.sample, exp_s);
        end
        tests++;
        if (b2.frame_cnt !== 8'(k / 8)) begin
          fails++;
          $display("FAIL cont_fc k=%0d got %0d want %0d", k, b2.frame_cnt, k / 8);
        end
      end
      if (k == 8) c2 = 4'b1111;
      if (k == 17) b2.continuous = 0;
    end
  endtask

  task automatic test_start_ignored();
    int vcnt;
    vcnt = 0;
    apply_reset();
    c4 = 4'b1101;
    b4.continuous = 0;
    b4.start = 1;
    @(negedge clk);
    b4.start = 0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) @(negedge clk);
      if (b4.valid) vcnt++;
      tests++;
      if (b4.valid !== (k == 16)) begin
        fails++;
        $display("FAIL ign_valid k=%0d got %b want %b", k, b4.valid, k == 16);
      end
      b4.start = (k == 3 || k == 10);
    end
    b4.start = 0;
    tests++;
    if (vcnt != 1) begin
      fails++;
      $display("FAIL ign_vcnt got %0d want 1", vcnt);
    end
    tests++;
    if (b4.frame_cnt !== 8'd1 || b4.busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_fc got fc=%0d busy=%b want fc=1 busy=0",
               b4.frame_cnt, b4.busy);
    end
  endtask

  task automatic test_async_reset();
    int vcnt;
    vcnt = 0;
    c4 = 4'b1101;
    b4.start = 1;
    @(negedge clk);
    b4.start = 0;
    repeat (9) @(negedge clk);
    tests++;
    if (b4.sel !== 2'd2 || b4.busy !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre got sel=%0d busy=%b want sel=2 busy=1",
               b4.sel, b4.busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({b4.sel, b4.busy, b4.sample, b4.valid, b4.frame_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL arst_now got sel=%0d busy=%b sample=%b valid=%b fc=%0d want all 0",
               b4.sel, b4.busy, b4.sample, b4.valid, b4.frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b4.start = 1;
    @(negedge clk);
    b4.start = 0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      if (b4.valid) vcnt++;
      if (k == 16) begin
        tests++;
        if (b4.valid !== 1'b1 || b4.sample !== 4'b1101 || b4.frame_cnt !== 8'd1) begin
          fails++;
          $display("FAIL arst_frame got valid=%b sample=%b fc=%0d want 1 1101 1",
                   b4.valid, b4.sample, b4.frame_cnt);
        end
      end
    end
    tests++;
    if (vcnt != 1) begin
      fails++;
      $display("FAIL arst_vcnt got %0d want 1", vcnt);
    end
  endtask

  task automatic test_dwell1_wrap();
    int  vcnt, bad_v, bad_c;
    logic prev_v;
    logic ev;
    vcnt = 0; bad_v = 0; bad_c = 0; prev_v = 0;
    apply_reset();
    c1 = 4'b0110;
    b1.continuous = 1;
    b1.start = 1;
    @(negedge clk);
    b1.start = 0;
    for (int k = 0; k <= 4100; k++) begin
      if (k > 0) @(negedge clk);
      ev = (k > 0) && (k % 4 == 0) && (k <= 4096);
      if (b1.valid) vcnt++;
      if (b1.valid !== ev) bad_v++;
      if (prev_v && b1.valid) bad_c++;
      prev_v = b1.valid;
      if (k == 1023) begin
        tests++;
        if (b1.frame_cnt !== 8'd255) begin
          fails++;
          $display("FAIL d1_fc255 got %0d want 255", b1.frame_cnt);
        end
      end
      if (k == 1024) begin
        tests++;
        if (b1.frame_cnt !== 8'd0 || b1.valid !== 1'b1) begin
          fails++;
          $display("FAIL d1_wrap got fc=%0d valid=%b want 0 1",
                   b1.frame_cnt, b1.valid);
        end
      end
      if (k == 4093) b1.continuous = 0;
    end
    tests++;
    if (vcnt != 1024) begin
      fails++;
      $display("FAIL d1_frames got %0d want 1024", vcnt);
    end
    tests++;
    if (bad_v != 0) begin
      fails++;
      $display("FAIL d1_valid_timing got %0d bad cycles want 0", bad_v);
    end
    tests++;
    if (bad_c != 0) begin
      fails++;
      $display("FAIL d1_consecutive got %0d want 0", bad_c);
    end
    tests++;
    if (b1.frame_cnt !== 8'd0 || b1.busy !== 1'b0 || b1.sel !== 2'd3) begin
      fails++;
      $display("FAIL d1_end got fc=%0d busy=%b sel=%0d want 0 0 3",
               b1.frame_cnt, b1.busy, b1.sel);
    end
    tests++;
    if (b1.sample !== 4'b0110) begin
      fails++;
      $display("FAIL d1_sample got %b want 0110", b1.sample);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_start_ignored();
    test_async_reset();
    test_dwell1_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
